// File: rtl/ioiq_bank_steer.sv
// ioiq_bank_steer: steers up to two renamed slots into two in-order IQ banks
// using per-bank credits and a round-robin preference pointer.
module ioiq_bank_steer #(
    parameter int BANK_DEPTH = 8,
    parameter int CNT_W      = $clog2(BANK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         in_valid,
    input  logic               ext_stall,
    input  logic               if_recall,
    input  logic [1:0]         bank_pop,
    input  logic [2*CNT_W-1:0] bank_occ_after_recall,
    output logic [1:0]         push_valid,
    output logic [1:0]         push_slot,
    output logic               int_stall,
    output logic [2*CNT_W-1:0] credit,
    output logic               rr_ptr,
    output logic               credit_err,
    output logic [15:0]        stall_cycles
);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BANK_DEPTH);

    logic [CNT_W-1:0] cr [2];
    logic pair, single, tgt, accept, go;

    assign credit = {cr[1], cr[0]};

    always_comb begin
        pair       = &in_valid;
        single     = ^in_valid;
        tgt        = (cr[0] == cr[1]) ? rr_ptr : (cr[1] > cr[0]);
        accept     = pair ? (cr[0] != '0 && cr[1] != '0) : single ? (cr[tgt] != '0) : 1'b0;
        go         = accept & ~ext_stall & ~if_recall & ~reset;
        push_valid = !go ? 2'b00 : pair ? 2'b11 : (2'b01 << tgt);
        // Pair: bank rr_ptr takes the older slot; single: both lanes carry the lone slot index.
        push_slot  = pair ? (rr_ptr ? 2'b01 : 2'b10) : {2{in_valid[1]}};
        int_stall  = reset ? ext_stall : if_recall ? 1'b0 : ext_stall | (|in_valid & ~accept);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cr[0]        <= FULL;
            cr[1]        <= FULL;
            rr_ptr       <= 1'b0;
            credit_err   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (if_recall) begin
                for (int b = 0; b < 2; b++)
                    cr[b] <= FULL - bank_occ_after_recall[b*CNT_W +: CNT_W];
                rr_ptr <= 1'b0;
            end else begin
                for (int b = 0; b < 2; b++)
                    if (bank_pop[b] && !push_valid[b] && cr[b] == FULL)
                        credit_err <= 1'b1;
                    else
                        cr[b] <= cr[b] - CNT_W'(push_valid[b]) + CNT_W'(bank_pop[b]);
                if (|push_valid)
                    rr_ptr <= pair ? ~rr_ptr : ~tgt;
            end
            if (int_stall && |in_valid && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end
endmodule

// File: doc/ioiq_bank_steer.md
# ioiq_bank_steer

Dispatch-side controller for the two-bank in-order issue queue. Each cycle it takes up to two renamed instructions (slot 0 older than slot 1) and steers each to one of the two in-order IQ banks. It tracks per-bank free-entry credits and holds a round-robin priority pointer. It raises the internal stall when the group cannot be placed in full, and reloads credits after a front-end recall.

## Interface
Parameters:
- BANK_DEPTH, 8: entries per IQ bank; credit counter reset/maximum value.
- CNT_W, $clog2(BANK_DEPTH+1): credit/occupancy width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  2  renamed slot valid; bit 0 = older slot.
- ext_stall  in  1  downstream stall; blocks all pushes.
- if_recall  in  1  front-end recall/flush this cycle.
- bank_pop  in  2  bank b dequeued (issued) one entry this cycle.
- bank_occ_after_recall  in  2×CNT_W  per-bank surviving occupancy after recall squash; valid when if_recall=1; already includes same-cycle pops.
- push_valid  out  2  write one entry into bank b.
- push_slot  out  2  for bank b, source slot index (0/1); don't-care when push_valid[b]=0.
- int_stall  out  1  group not accepted this cycle.
- credit  out  2×CNT_W  registered free-entry count per bank.
- rr_ptr  out  1  registered preferred bank for the older slot.
- credit_err  out  1  sticky: pop seen with credit already at BANK_DEPTH.
- stall_cycles  out  16  saturating count of cycles with int_stall=1 and any in_valid.

## Operation
- State: credit[0..1], rr_ptr, credit_err, stall_cycles. Outputs push_valid/push_slot/int_stall are combinational from the current state and inputs.
- Each bank accepts at most one push per cycle. A group is all-or-nothing.
- Steering when ext_stall=0 and if_recall=0:
  - in_valid=2'b11: accepted iff credit[0]≥1 and credit[1]≥1. Slot 0 goes to bank rr_ptr; slot 1 goes to bank ~rr_ptr.
  - Exactly one slot valid: goes to the bank with the larger credit. On a tie it goes to bank rr_ptr. It is accepted iff the chosen bank's credit ≥1.
  - in_valid=0: no push, int_stall=0.
- int_stall = ext_stall | (any in_valid & group not accepted). if_recall forces push_valid=0 and int_stall=0.
- rr_ptr update on an accepted pair: flips. On an accepted single push to bank b: rr_ptr <= ~b. Otherwise it holds.
- Credit update (no recall): credit[b] <= credit[b] − push_valid[b] + bank_pop[b].
  - Push with credit=0 cannot occur by construction.
  - Pop when credit=BANK_DEPTH and no same-cycle push: credit holds at BANK_DEPTH and credit_err <= 1.
- Recall: credit[b] <= BANK_DEPTH − bank_occ_after_recall[b]. bank_pop is ignored that cycle. rr_ptr <= 0.
- stall_cycles increments when int_stall & |in_valid, and saturates at 16'hFFFF.
- Pops are honoured during ext_stall.

## Timing
- Reset (async): credit[b]=BANK_DEPTH, rr_ptr=0, credit_err=0, stall_cycles=0.
  - push_valid=0 while reset is asserted.
  - int_stall follows ext_stall while reset is asserted.
- Steering decision is zero-latency, same cycle as in_valid. Credits reflect a push/pop from the next cycle.
- A credit freed by a pop in cycle N is usable for a push in cycle N+1, not in cycle N.
- Recall in cycle N: reloaded credits are visible in cycle N+1, and pushes may resume in N+1.
- Reset asserted mid-operation: state clears immediately, with no partial update on the following edge.

## Test plan
- Reset, then in_valid=11 every cycle with no pops: pushes alternate slot 0 → bank 0, 1, 0, …. Stall begins on cycle 9 (BANK_DEPTH=8) once both credits reach 0. stall_cycles counts from there.
- credit={3,1}, in_valid=01: slot 0 → bank 0. Then credit={2,1}, tie-free, in_valid=01 → bank 0 again. With credit={1,1} and rr_ptr=1 → bank 1.
- credit={0,5}, in_valid=11: int_stall=1 and no push, even though bank 1 has 5 credits. A pop on bank 0 that cycle → accepted the next cycle.
- Hold ext_stall=1 with pops on both banks for 3 cycles: no pushes, both credits rise by 3.
- if_recall with in_valid=11, bank_occ_after_recall={2,6}: no push and int_stall=0 that cycle. Next cycle credit={6,2} and rr_ptr=0.
- bank_pop[1]=1 with credit[1]=8: credit stays 8 and credit_err latches to 1 until reset.
